pipe_segment_skid: RTL and testbench

Generic, parametrised pipeline-segment register that succeeds the fixed per-stage segment registers (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries a control field and a data field between stages under a valid/ready handshake, with an optional 2-entry skid buffer. Provides synchronous stall and flush, bubble insertion (control zeroed when empty) and a saturating stall counter for profiling. Drops in between any two stages of the pipelined CPU.

---
 rtl/pipe_pkg.sv | 11 +
 rtl/sat_counter.sv | 21 ++
 rtl/pipe_segment_skid.sv | 130 +++++++++++++
 tb/tb_pipe_segment_skid.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the generic pipeline segment register: state encoding
// doubles as the registered occupancy count.
package pipe_pkg;
    localparam int OCC_W = 2;

    typedef enum logic [OCC_W-1:0] {
        PS_EMPTY = 2'd0,
        PS_HALF  = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on each enabled edge, sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count
);
    logic [W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (en && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;
endmodule

// File: rtl/pipe_segment_skid.sv
// Parametrised valid/ready pipeline segment with optional two-entry skid
// buffer, stall/flush, bubble zeroing of control and a stall profiler.
module pipe_segment_skid
    import pipe_pkg::*;
#(
    parameter int DW      = 32,
    parameter int CW      = 8,
    parameter int SKID    = 1,
    parameter int NEGEDGE = 1,
    parameter int SW      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CW-1:0]    in_ctrl,
    input  logic [DW-1:0]    in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_ctrl,
    output logic [DW-1:0]    out_data,
    output logic [OCC_W-1:0] occupancy,
    output logic [SW-1:0]    stall_cnt
);
    logic cap_clk;

    // All state shares one capture edge; the falling-edge variant simply
    // runs the same registers off an inverted clock.
    generate
        if (NEGEDGE != 0) begin : g_neg
            assign cap_clk = ~clk;
        end else begin : g_pos
            assign cap_clk = clk;
        end
    endgenerate

    pipe_state_t   state_reg, state_next;
    logic [CW-1:0] main_ctrl_reg, main_ctrl_next;
    logic [DW-1:0] main_data_reg, main_data_next;
    logic [CW-1:0] skid_ctrl_reg, skid_ctrl_next;
    logic [DW-1:0] skid_data_reg, skid_data_next;
    logic          accept;
    logic          consume;

    assign out_valid = (state_reg != PS_EMPTY);
    assign in_ready  = ~stall & ((SKID != 0) ? (state_reg != PS_FULL)
                                             : (~out_valid | out_ready));
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready & ~stall;

    always_comb begin
        state_next     = state_reg;
        main_ctrl_next = main_ctrl_reg;
        main_data_next = main_data_reg;
        skid_ctrl_next = skid_ctrl_reg;
        skid_data_next = skid_data_reg;
        if (flush) begin
            // Head data is left in place so out_data keeps its last value.
            state_next     = PS_EMPTY;
            skid_ctrl_next = '0;
            skid_data_next = '0;
        end else begin
            case (state_reg)
                PS_EMPTY: begin
                    if (accept) begin
                        state_next     = PS_HALF;
                        main_ctrl_next = in_ctrl;
                        main_data_next = in_data;
                    end
                end
                PS_HALF: begin
                    if (accept && consume) begin
                        main_ctrl_next = in_ctrl;
                        main_data_next = in_data;
                    end else if (accept) begin
                        if (SKID != 0) begin
                            state_next     = PS_FULL;
                            skid_ctrl_next = in_ctrl;
                            skid_data_next = in_data;
                        end
                    end else if (consume) begin
                        state_next = PS_EMPTY;
                    end
                end
                PS_FULL: begin
                    if (consume) begin
                        state_next     = PS_HALF;
                        main_ctrl_next = skid_ctrl_reg;
                        main_data_next = skid_data_reg;
                        skid_ctrl_next = '0;
                        skid_data_next = '0;
                    end
                end
                default: state_next = PS_EMPTY;
            endcase
        end
    end

    always_ff @(posedge cap_clk or posedge rst) begin
        if (rst) begin
            state_reg     <= PS_EMPTY;
            main_ctrl_reg <= '0;
            main_data_reg <= '0;
            skid_ctrl_reg <= '0;
            skid_data_reg <= '0;
        end else begin
            state_reg     <= state_next;
            main_ctrl_reg <= main_ctrl_next;
            main_data_reg <= main_data_next;
            skid_ctrl_reg <= skid_ctrl_next;
            skid_data_reg <= skid_data_next;
        end
    end

    // Empty slot presents a bubble: control forced inert, data left stale.
    assign out_ctrl  = out_valid ? main_ctrl_reg : '0;
    assign out_data  = main_data_reg;
    assign occupancy = state_reg;

    sat_counter #(
        .W(SW)
    ) u_stall_cnt (
        .clk   (cap_clk),
        .rst   (rst),
        .en    (stall),
        .count (stall_cnt)
    );
endmodule

// File: tb/tb_pipe_segment_skid.sv
// Directed bench: instance a uses defaults (skid, falling edge), instance b
// is single-register, rising-edge with a 2-bit stall counter.
module tb_pipe_segment_skid;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_stall, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0]  a_in_ctrl, a_out_ctrl;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_occ;
    logic [15:0] a_stall_cnt;

    logic        b_stall, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0]  b_in_ctrl, b_out_ctrl;
    logic [31:0] b_in_data, b_out_data;
    logic [1:0]  b_occ;
    logic [1:0]  b_stall_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    pipe_segment_skid u_a (
        .clk(clk), .rst(rst), .stall(a_stall), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
        .occupancy(a_occ), .stall_cnt(a_stall_cnt)
    );

    pipe_segment_skid #(.SKID(0), .NEGEDGE(0), .SW(2)) u_b (
        .clk(clk), .rst(rst), .stall(b_stall), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
        .occupancy(b_occ), .stall_cnt(b_stall_cnt)
    );

    task automatic a_edge();
        @(negedge clk); #1;
    endtask

    task automatic b_edge();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        a_stall = 0; a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_in_ctrl = 0; a_in_data = 0;
        b_stall = 0; b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_in_ctrl = 0; b_in_data = 0;
        rst = 1;
        #23;
        total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", a_out_valid); else pass_cnt++;
        total_cnt++; if (a_occ !== 2'd0) $display("FAIL reset_occ: got %0d want 0", a_occ); else pass_cnt++;
        total_cnt++; if (a_out_ctrl !== 8'h00 || a_out_data !== 32'h0) $display("FAIL reset_out: got %h/%h want 00/0", a_out_ctrl, a_out_data); else pass_cnt++;
        total_cnt++; if (a_stall_cnt !== 16'd0) $display("FAIL reset_stall_cnt: got %0d want 0", a_stall_cnt); else pass_cnt++;
        total_cnt++; if (a_in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", a_in_ready); else pass_cnt++;
        a_edge();
        rst = 0;
        $display("reset released at %0t", $time);
    endtask

    task automatic test_stream();
        logic [31:0] d [3];
        d[0] = 32'h1; d[1] = 32'h2; d[2] = 32'h3;
        a_out_ready = 1;
        a_in_valid  = 1;
        for (int i = 0; i < 3; i++) begin
            a_in_data = d[i];
            a_in_ctrl = 8'(i + 1);
            a_edge();
            $display("stream: pushed %h, head %h", d[i], a_out_data);
            total_cnt++; if (a_out_data !== d[i] || a_out_valid !== 1'b1) $display("FAIL stream_data%0d: got %h v%0b want %h v1", i, a_out_data, a_out_valid, d[i]); else pass_cnt++;
            total_cnt++; if (a_occ !== 2'd1 || a_out_ctrl !== 8'(i + 1)) $display("FAIL stream_occ%0d: got occ %0d ctrl %h want 1 %h", i, a_occ, a_out_ctrl, 8'(i + 1)); else pass_cnt++;
        end
        a_in_valid = 0;
        a_edge();
        total_cnt++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 8'h00 || a_out_data !== 32'h3) $display("FAIL stream_drain: got v%0b ctrl %h data %h want v0 00 3", a_out_valid, a_out_ctrl, a_out_data); else pass_cnt++;
    endtask

    task automatic test_skid();
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 32'hA; a_in_ctrl = 8'h11;
        a_edge();
        a_in_data = 32'hB; a_in_ctrl = 8'h22;
        a_edge();
        a_in_valid = 0;
        $display("skid: filled, occ %0d head %h", a_occ, a_out_data);
        total_cnt++; if (a_occ !== 2'd2 || a_in_ready !== 1'b0) $display("FAIL skid_full: got occ %0d rdy %0b want 2 0", a_occ, a_in_ready); else pass_cnt++;
        total_cnt++; if (a_out_data !== 32'hA || a_out_ctrl !== 8'h11) $display("FAIL skid_head: got %h/%h want A/11", a_out_data, a_out_ctrl); else pass_cnt++;
        a_out_ready = 1;
        a_edge();
        total_cnt++; if (a_out_data !== 32'hB || a_out_ctrl !== 8'h22 || a_occ !== 2'd1) $display("FAIL skid_second: got %h/%h occ %0d want B/22 1", a_out_data, a_out_ctrl, a_occ); else pass_cnt++;
        a_edge();
        total_cnt++; if (a_occ !== 2'd0 || a_out_valid !== 1'b0) $display("FAIL skid_empty: got occ %0d v%0b want 0 0", a_occ, a_out_valid); else pass_cnt++;
    endtask

    task automatic test_stall();
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 32'h55; a_in_ctrl = 8'h05;
        a_edge();
        a_stall = 1; a_out_ready = 1; a_in_data = 32'h66; a_in_ctrl = 8'h06;
        #1;
        total_cnt++; if (a_in_ready !== 1'b0) $display("FAIL stall_in_ready: got %0b want 0", a_in_ready); else pass_cnt++;
        for (int i = 0; i < 3; i++) a_edge();
        $display("stall: head %h occ %0d cnt %0d", a_out_data, a_occ, a_stall_cnt);
        total_cnt++; if (a_out_data !== 32'h55 || a_occ !== 2'd1) $display("FAIL stall_hold: got %h occ %0d want 55 1", a_out_data, a_occ); else pass_cnt++;
        total_cnt++; if (a_stall_cnt !== 16'd3) $display("FAIL stall_cnt: got %0d want 3", a_stall_cnt); else pass_cnt++;
        a_stall = 0; a_in_valid = 0;
        a_edge();
        total_cnt++; if (a_occ !== 2'd0 || a_stall_cnt !== 16'd3) $display("FAIL stall_release: got occ %0d cnt %0d want 0 3", a_occ, a_stall_cnt); else pass_cnt++;
    endtask

    task automatic test_flush();
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 32'h77; a_in_ctrl = 8'hA5;
        a_edge();
        a_in_data = 32'h88; a_in_ctrl = 8'h5A;
        a_edge();
        a_flush = 1; a_in_data = 32'h99; a_in_ctrl = 8'h3C;
        a_edge();
        a_flush = 0; a_in_valid = 0;
        $display("flush: occ %0d head %h", a_occ, a_out_data);
        total_cnt++; if (a_occ !== 2'd0 || a_out_valid !== 1'b0 || a_out_ctrl !== 8'h00) $display("FAIL flush_empty: got occ %0d v%0b ctrl %h want 0 0 00", a_occ, a_out_valid, a_out_ctrl); else pass_cnt++;
        total_cnt++; if (a_out_data !== 32'h77) $display("FAIL flush_data_hold: got %h want 77", a_out_data); else pass_cnt++;
        a_out_ready = 1;
        a_edge();
        total_cnt++; if (a_out_valid !== 1'b0 || a_out_data !== 32'h77) $display("FAIL flush_no_emit: got v%0b %h want v0 77", a_out_valid, a_out_data); else pass_cnt++;
    endtask

    task automatic test_negedge_a();
        a_in_valid = 1; a_in_data = 32'hC0DE; a_in_ctrl = 8'h0C;
        @(posedge clk); #1;
        total_cnt++; if (a_out_valid !== 1'b0) $display("FAIL neg_no_rise: got v%0b want 0", a_out_valid); else pass_cnt++;
        @(negedge clk); #1;
        a_in_valid = 0;
        $display("negedge: head %h", a_out_data);
        total_cnt++; if (a_out_valid !== 1'b1 || a_out_data !== 32'hC0DE) $display("FAIL neg_fall: got v%0b %h want v1 c0de", a_out_valid, a_out_data); else pass_cnt++;
        a_edge();
    endtask

    task automatic test_b_single();
        b_edge();
        b_in_valid = 1; b_in_data = 32'h1234; b_in_ctrl = 8'h42; b_out_ready = 0;
        @(negedge clk); #1;
        total_cnt++; if (b_out_valid !== 1'b0) $display("FAIL pos_no_fall: got v%0b want 0", b_out_valid); else pass_cnt++;
        b_edge();
        b_in_valid = 0;
        $display("single: head %h occ %0d", b_out_data, b_occ);
        total_cnt++; if (b_out_valid !== 1'b1 || b_out_data !== 32'h1234 || b_out_ctrl !== 8'h42) $display("FAIL pos_rise: got v%0b %h/%h want v1 1234/42", b_out_valid, b_out_data, b_out_ctrl); else pass_cnt++;
        total_cnt++; if (b_in_ready !== 1'b0) $display("FAIL noskid_in_ready: got %0b want 0", b_in_ready); else pass_cnt++;
        b_out_ready = 1;
        #1;
        total_cnt++; if (b_in_ready !== 1'b1) $display("FAIL noskid_ready_pass: got %0b want 1", b_in_ready); else pass_cnt++;
        b_edge();
        total_cnt++; if (b_occ !== 2'd0 || b_out_ctrl !== 8'h00) $display("FAIL noskid_drain: got occ %0d ctrl %h want 0 00", b_occ, b_out_ctrl); else pass_cnt++;
    endtask

    task automatic test_b_saturate();
        b_stall = 1;
        b_edge(); b_edge();
        total_cnt++; if (b_stall_cnt !== 2'd2) $display("FAIL sat_count2: got %0d want 2", b_stall_cnt); else pass_cnt++;
        b_edge(); b_edge(); b_edge();
        b_stall = 0;
        $display("saturate: cnt %0d", b_stall_cnt);
        total_cnt++; if (b_stall_cnt !== 2'd3) $display("FAIL sat_count5: got %0d want 3", b_stall_cnt); else pass_cnt++;
    endtask

    task automatic test_reset_full();
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 32'h11; a_in_ctrl = 8'hA5;
        a_edge();
        a_in_data = 32'h22; a_in_ctrl = 8'h5A;
        a_edge();
        a_in_valid = 0;
        total_cnt++; if (a_occ !== 2'd2 || a_out_ctrl !== 8'hA5) $display("FAIL rstfull_pre: got occ %0d ctrl %h want 2 a5", a_occ, a_out_ctrl); else pass_cnt++;
        rst = 1;
        #1;
        $display("reset in full: occ %0d v%0b", a_occ, a_out_valid);
        total_cnt++; if (a_out_valid !== 1'b0 || a_out_ctrl !== 8'h00 || a_occ !== 2'd0) $display("FAIL rstfull_async: got v%0b ctrl %h occ %0d want 0 00 0", a_out_valid, a_out_ctrl, a_occ); else pass_cnt++;
        total_cnt++; if (a_in_ready !== 1'b1 || a_stall_cnt !== 16'd0) $display("FAIL rstfull_ready: got rdy %0b cnt %0d want 1 0", a_in_ready, a_stall_cnt); else pass_cnt++;
        a_edge();
        rst = 0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_stall();
        test_flush();
        test_negedge_a();
        test_b_single();
        test_b_saturate();
        test_reset_full();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
